// File: rtl/ddr_axi_master.sv
// AXI4 master that turns single word-oriented burst requests into AW/W/B or AR/R sequences
// toward the DDR controller and reports one merged completion per request.
module ddr_axi_master #(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter int         MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [27:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic [3:0]  ddr_awid,
    output logic [27:0] ddr_awaddr,
    output logic [7:0]  ddr_awlen,
    output logic [2:0]  ddr_awsize,
    output logic [1:0]  ddr_awburst,
    output logic [3:0]  ddr_awcache,
    output logic [2:0]  ddr_awprot,
    output logic [3:0]  ddr_awqos,
    output logic        ddr_awvalid,
    input  logic        ddr_awready,
    output logic [31:0] ddr_wdata,
    output logic [3:0]  ddr_wstrb,
    output logic        ddr_wlast,
    output logic        ddr_wvalid,
    input  logic        ddr_wready,
    input  logic [3:0]  ddr_bid,
    input  logic [1:0]  ddr_bresp,
    input  logic        ddr_bvalid,
    output logic        ddr_bready,
    output logic [3:0]  ddr_arid,
    output logic [27:0] ddr_araddr,
    output logic [7:0]  ddr_arlen,
    output logic [2:0]  ddr_arsize,
    output logic [1:0]  ddr_arburst,
    output logic [3:0]  ddr_arcache,
    output logic [2:0]  ddr_arprot,
    output logic [3:0]  ddr_arqos,
    output logic        ddr_arvalid,
    input  logic        ddr_arready,
    input  logic [3:0]  ddr_rid,
    input  logic [31:0] ddr_rdata,
    input  logic [1:0]  ddr_rresp,
    input  logic        ddr_rlast,
    input  logic        ddr_rvalid,
    output logic        ddr_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  resp_q, resp_d;
    logic        lerr_q, lerr_d;
    logic [13:0] end_off;
    logic        bad_req;
    logic        last_beat;
    logic        unused_ids;

    // Byte offset one past the burst end inside the current 4 KiB page.
    assign end_off   = {2'b00, req_addr[11:2], 2'b00} + {4'b0000, req_len, 2'b00} + 14'd4;
    assign bad_req   = (32'(req_len) > 32'(MAX_LEN)) || (end_off > 14'd4096);
    assign last_beat = (cnt_q == len_q);
    assign unused_ids = ^{ddr_bid, ddr_rid};

    assign ddr_awid    = AXI_ID;
    assign ddr_awaddr  = addr_q;
    assign ddr_awlen   = len_q;
    assign ddr_awsize  = 3'b010;
    assign ddr_awburst = 2'b01;
    assign ddr_awcache = 4'b0011;
    assign ddr_awprot  = 3'b000;
    assign ddr_awqos   = 4'b0000;
    assign ddr_arid    = AXI_ID;
    assign ddr_araddr  = addr_q;
    assign ddr_arlen   = len_q;
    assign ddr_arsize  = 3'b010;
    assign ddr_arburst = 2'b01;
    assign ddr_arcache = 4'b0011;
    assign ddr_arprot  = 3'b000;
    assign ddr_arqos   = 4'b0000;
    assign ddr_wdata   = wr_data;
    assign ddr_wstrb   = wr_strb;
    assign rd_data     = ddr_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        lerr_d      = lerr_q;
        req_ready   = 1'b0;
        ddr_awvalid = 1'b0;
        ddr_wvalid  = 1'b0;
        ddr_wlast   = 1'b0;
        wr_ready    = 1'b0;
        ddr_bready  = 1'b0;
        ddr_arvalid = 1'b0;
        ddr_rready  = 1'b0;
        rd_valid    = 1'b0;
        rd_last     = 1'b0;
        done        = 1'b0;
        done_resp   = 2'b00;
        case (state_q)
            S_IDLE: begin
                // rstn gate keeps req_ready low while reset is held.
                req_ready = rstn;
                if (req_valid) begin
                    addr_d = {req_addr[27:2], 2'b00};
                    len_d  = req_len;
                    cnt_d  = '0;
                    resp_d = 2'b00;
                    lerr_d = 1'b0;
                    if (bad_req) begin
                        resp_d  = 2'b10;
                        state_d = S_DONE;
                    end else begin
                        state_d = req_we ? S_WADDR : S_RADDR;
                    end
                end
            end
            S_WADDR: begin
                ddr_awvalid = 1'b1;
                if (ddr_awready) state_d = S_WDATA;
            end
            S_WDATA: begin
                ddr_wvalid = wr_valid;
                wr_ready   = ddr_wready;
                ddr_wlast  = last_beat;
                if (wr_valid && ddr_wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                ddr_bready = 1'b1;
                if (ddr_bvalid) begin
                    resp_d  = ddr_bresp;
                    state_d = S_DONE;
                end
            end
            S_RADDR: begin
                ddr_arvalid = 1'b1;
                if (ddr_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                rd_valid   = ddr_rvalid;
                ddr_rready = rd_ready;
                rd_last    = last_beat;
                if (ddr_rvalid && rd_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (ddr_rresp > resp_q) resp_d = ddr_rresp;
                    // A slave whose rlast disagrees with the requested length is flagged, not trusted.
                    if (ddr_rlast != last_beat) lerr_d = 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                done_resp = lerr_q ? 2'b10 : resp_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr_axi_master.sv
// Randomized scoreboard bench for ddr_axi_master: a behavioural AXI slave with stalls,
// a host-side driver, and a word-level reference model that predicts every beat and completion.
`timescale 1ns/1ps
module tb_ddr_axi_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [27:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;
    logic [3:0]  ddr_awid, ddr_arid, ddr_awcache, ddr_arcache, ddr_awqos, ddr_arqos;
    logic [27:0] ddr_awaddr, ddr_araddr;
    logic [7:0]  ddr_awlen, ddr_arlen;
    logic [2:0]  ddr_awsize, ddr_arsize, ddr_awprot, ddr_arprot;
    logic [1:0]  ddr_awburst, ddr_arburst;
    logic        ddr_awvalid, ddr_awready, ddr_arvalid, ddr_arready;
    logic [31:0] ddr_wdata, ddr_rdata;
    logic [3:0]  ddr_wstrb, ddr_bid, ddr_rid;
    logic        ddr_wlast, ddr_wvalid, ddr_wready;
    logic [1:0]  ddr_bresp, ddr_rresp;
    logic        ddr_bvalid, ddr_bready, ddr_rlast, ddr_rvalid, ddr_rready;

    always #5 clk = ~clk;

    ddr_axi_master dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .ddr_awid(ddr_awid), .ddr_awaddr(ddr_awaddr), .ddr_awlen(ddr_awlen),
        .ddr_awsize(ddr_awsize), .ddr_awburst(ddr_awburst), .ddr_awcache(ddr_awcache),
        .ddr_awprot(ddr_awprot), .ddr_awqos(ddr_awqos), .ddr_awvalid(ddr_awvalid),
        .ddr_awready(ddr_awready),
        .ddr_wdata(ddr_wdata), .ddr_wstrb(ddr_wstrb), .ddr_wlast(ddr_wlast),
        .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready),
        .ddr_bid(ddr_bid), .ddr_bresp(ddr_bresp), .ddr_bvalid(ddr_bvalid), .ddr_bready(ddr_bready),
        .ddr_arid(ddr_arid), .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen),
        .ddr_arsize(ddr_arsize), .ddr_arburst(ddr_arburst), .ddr_arcache(ddr_arcache),
        .ddr_arprot(ddr_arprot), .ddr_arqos(ddr_arqos), .ddr_arvalid(ddr_arvalid),
        .ddr_arready(ddr_arready),
        .ddr_rid(ddr_rid), .ddr_rdata(ddr_rdata), .ddr_rresp(ddr_rresp), .ddr_rlast(ddr_rlast),
        .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready)
    );

    typedef struct { logic [27:0] addr; logic [7:0] len; } ax_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wb_t;
    typedef struct { logic [31:0] data; logic last; } rb_t;

    ax_t         exp_aw[$], exp_ar[$];
    wb_t         exp_w[$], wq[$];
    rb_t         exp_rd[$];
    logic [1:0]  exp_done[$];
    logic [31:0] ref_mem[int];
    logic [31:0] s_mem[int];

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_wfire = 0;
    int          rdy_pct = 100;
    int          host_pct = 100;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp[256];
    int          cfg_rlast_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic rnd(input int pct);
        return ($urandom_range(99, 0) < 32'(pct));
    endfunction

    // ---------------- slave, host driver and monitor ----------------
    logic        aw_f, w_f, b_f, ar_f, r_f;
    ax_t         aw_s, ar_s;
    logic [31:0] wd_s;
    logic [3:0]  ws_s;
    logic        prev_awv, prev_arv, prev_done;
    logic [27:0] prev_awaddr, prev_araddr;
    int          s_wptr, s_wcnt, s_wlen, s_rptr, s_rcnt, s_rlen;
    logic        s_w_active, b_pend, r_active;

    initial begin : env
        ax_t ax;
        wb_t wb;
        rb_t rb;
        logic [1:0] dr;
        {ddr_awready, ddr_wready, ddr_bvalid, ddr_arready, ddr_rvalid, ddr_rlast} = '0;
        ddr_bresp = '0; ddr_rresp = '0; ddr_rdata = '0; ddr_bid = '0; ddr_rid = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        {prev_awv, prev_arv, prev_done, s_w_active, b_pend, r_active} = '0;
        prev_awaddr = '0; prev_araddr = '0;
        forever begin
            @(negedge clk);
            {aw_f, w_f, b_f, ar_f, r_f} = '0;
            if (rstn) begin
                aw_f = ddr_awvalid & ddr_awready;
                w_f  = ddr_wvalid & ddr_wready;
                b_f  = ddr_bvalid & ddr_bready;
                ar_f = ddr_arvalid & ddr_arready;
                r_f  = ddr_rvalid & ddr_rready;
                if (ddr_awvalid) chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                if (ddr_arvalid) chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
                if (prev_awv) chk("aw_stable", 64'({ddr_awvalid, ddr_awaddr}), 64'({1'b1, prev_awaddr}));
                if (prev_arv) chk("ar_stable", 64'({ddr_arvalid, ddr_araddr}), 64'({1'b1, prev_araddr}));
                if (aw_f && exp_aw.size() != 0) begin
                    ax = exp_aw.pop_front();
                    chk("awaddr", 64'(ddr_awaddr), 64'(ax.addr));
                    chk("awlen", 64'(ddr_awlen), 64'(ax.len));
                    chk("aw_const", 64'({ddr_awid, ddr_awsize, ddr_awburst, ddr_awcache, ddr_awprot, ddr_awqos}),
                        64'({4'h0, 3'b010, 2'b01, 4'b0011, 3'b000, 4'h0}));
                end
                aw_s = '{ddr_awaddr, ddr_awlen};
                if (ar_f && exp_ar.size() != 0) begin
                    ax = exp_ar.pop_front();
                    chk("araddr", 64'(ddr_araddr), 64'(ax.addr));
                    chk("arlen", 64'(ddr_arlen), 64'(ax.len));
                    chk("ar_const", 64'({ddr_arid, ddr_arsize, ddr_arburst, ddr_arcache, ddr_arprot, ddr_arqos}),
                        64'({4'h0, 3'b010, 2'b01, 4'b0011, 3'b000, 4'h0}));
                end
                ar_s = '{ddr_araddr, ddr_arlen};
                if (w_f) begin
                    n_wfire++;
                    chk("w_after_aw", 64'(s_w_active), 64'd1);
                    chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
                    if (exp_w.size() != 0) begin
                        wb = exp_w.pop_front();
                        chk("wdata", 64'(ddr_wdata), 64'(wb.data));
                        chk("wstrb", 64'(ddr_wstrb), 64'(wb.strb));
                        chk("wlast", 64'(ddr_wlast), 64'(wb.last));
                    end
                end
                wd_s = ddr_wdata; ws_s = ddr_wstrb;
                if (rd_valid && rd_ready) begin
                    chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
                    if (exp_rd.size() != 0) begin
                        rb = exp_rd.pop_front();
                        chk("rd_data", 64'(rd_data), 64'(rb.data));
                        chk("rd_last", 64'(rd_last), 64'(rb.last));
                    end
                end
                if (done) begin
                    chk("done_pulse", 64'(prev_done), 64'd0);
                    chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                    if (exp_done.size() != 0) begin
                        dr = exp_done.pop_front();
                        chk("done_resp", 64'(done_resp), 64'(dr));
                    end
                end
                prev_awv = ddr_awvalid & ~ddr_awready; prev_awaddr = ddr_awaddr;
                prev_arv = ddr_arvalid & ~ddr_arready; prev_araddr = ddr_araddr;
                prev_done = done;
            end else begin
                {prev_awv, prev_arv, prev_done} = '0;
            end
            @(posedge clk); #1;
            if (!rstn) begin
                exp_aw.delete(); exp_ar.delete(); exp_w.delete(); wq.delete();
                exp_rd.delete(); exp_done.delete();
                {s_w_active, b_pend, r_active} = '0;
                {ddr_awready, ddr_wready, ddr_bvalid, ddr_arready, ddr_rvalid, ddr_rlast} = '0;
                wr_valid = 0; rd_ready = 0;
                continue;
            end
            if (aw_f) begin
                s_wptr = int'(aw_s.addr[27:2]); s_wcnt = 0; s_wlen = int'(aw_s.len); s_w_active = 1;
            end
            if (w_f) begin
                s_mem[s_wptr + s_wcnt] = merge(s_mem.exists(s_wptr + s_wcnt) ? s_mem[s_wptr + s_wcnt] : 32'h0,
                                               wd_s, ws_s);
                if (s_wcnt == s_wlen) begin s_w_active = 0; b_pend = 1; end
                s_wcnt++;
                if (wq.size() != 0) void'(wq.pop_front());
                wr_valid = 0;
            end
            if (b_f) begin ddr_bvalid = 0; b_pend = 0; end
            if (ar_f) begin
                s_rptr = int'(ar_s.addr[27:2]); s_rcnt = 0; s_rlen = int'(ar_s.len); r_active = 1;
            end
            if (r_f) begin
                ddr_rvalid = 0; s_rcnt++;
                if (s_rcnt > s_rlen) r_active = 0;
            end
            ddr_awready = rnd(rdy_pct);
            ddr_arready = rnd(rdy_pct);
            ddr_wready  = rnd(rdy_pct);
            if (b_pend && !ddr_bvalid && rnd(rdy_pct)) begin ddr_bvalid = 1; ddr_bresp = cfg_bresp; end
            if (r_active && !ddr_rvalid && rnd(rdy_pct)) begin
                ddr_rvalid = 1;
                ddr_rdata  = s_mem.exists(s_rptr + s_rcnt) ? s_mem[s_rptr + s_rcnt] : 32'h0;
                ddr_rresp  = cfg_rresp[s_rcnt];
                ddr_rlast  = (s_rcnt == ((cfg_rlast_beat >= 0) ? cfg_rlast_beat : s_rlen));
            end
            if (!wr_valid && wq.size() != 0 && rnd(host_pct)) begin
                wr_valid = 1; wr_data = wq[0].data; wr_strb = wq[0].strb;
            end
            rd_ready = rnd(host_pct);
        end
    end

    // ---------------- reference model and request driver ----------------
    task automatic issue(input logic we, input logic [27:0] addr, input int len,
                         input logic rnd_data, input logic [31:0] base);
        int         widx = int'(addr[27:2]);
        int         off  = int'(addr[11:0]) & ~3;
        logic [1:0] mx = 2'b00;
        logic [31:0] d;
        logic [3:0]  s;
        bit          ok = 0;
        if (off + 4 * (len + 1) > 4096) begin
            exp_done.push_back(2'b10);
        end else if (we) begin
            exp_aw.push_back('{{addr[27:2], 2'b00}, 8'(len)});
            for (int i = 0; i <= len; i++) begin
                d = rnd_data ? $urandom : base + 32'(i);
                s = rnd_data ? 4'($urandom) : 4'hF;
                wq.push_back('{d, s, i == len});
                exp_w.push_back('{d, s, i == len});
                ref_mem[widx + i] = merge(ref_mem.exists(widx + i) ? ref_mem[widx + i] : 32'h0, d, s);
            end
            exp_done.push_back(cfg_bresp);
        end else begin
            exp_ar.push_back('{{addr[27:2], 2'b00}, 8'(len)});
            for (int i = 0; i <= len; i++) begin
                exp_rd.push_back('{ref_mem.exists(widx + i) ? ref_mem[widx + i] : 32'h0, i == len});
                if (cfg_rresp[i] > mx) mx = cfg_rresp[i];
            end
            if (cfg_rlast_beat >= 0 && cfg_rlast_beat != len) mx = 2'b10;
            exp_done.push_back(mx);
        end
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_addr = addr; req_len = 8'(len);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (exp_done.size() == 0 && exp_rd.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete(); exp_done.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valids"}, 64'({ddr_awvalid, ddr_wvalid, ddr_bready, ddr_arvalid, ddr_rready,
                                   wr_ready, rd_valid, done}), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_done_resp"}, 64'(done_resp), 64'd0);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 256; i++) cfg_rresp[i] = 2'b00;
        cfg_bresp = 2'b00; cfg_rlast_beat = -1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int len, nw0;
        logic [27:0] a;
        rstn = 0; req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
        clear_cfg();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("por");
        @(posedge clk); #1 rstn = 1;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        issue(1, 28'h0000100, 0, 0, 32'hDEADBEEF);
        wait_done("wr_single");

        rdy_pct = 60; host_pct = 70;
        issue(1, 28'h0000200, 7, 1, 32'h0);
        wait_done("wr_burst8");
        issue(0, 28'h0000200, 7, 0, 32'h0);
        wait_done("rd_burst8");

        cfg_rresp[0] = 2'b00; cfg_rresp[1] = 2'b01; cfg_rresp[2] = 2'b10; cfg_rresp[3] = 2'b00;
        issue(0, 28'h0000200, 3, 0, 32'h0);
        wait_done("rd_resp_merge");
        clear_cfg();

        issue(1, 28'h0000FF8, 3, 1, 32'h0);
        @(negedge clk);
        chk("cross_wr_done_next", 64'({done, done_resp}), 64'({1'b1, 2'b10}));
        wait_done("cross_wr");
        issue(0, 28'h0000FF8, 3, 0, 32'h0);
        @(negedge clk);
        chk("cross_rd_done_next", 64'({done, done_resp}), 64'({1'b1, 2'b10}));
        wait_done("cross_rd");
        issue(1, 28'h0000FF0, 3, 1, 32'h0);
        wait_done("page_end_wr");
        issue(0, 28'h0000FF0, 3, 0, 32'h0);
        wait_done("page_end_rd");

        cfg_rlast_beat = 1;
        issue(0, 28'h0000200, 3, 0, 32'h0);
        wait_done("rd_early_rlast");
        clear_cfg();

        rdy_pct = 50; host_pct = 100;
        nw0 = n_wfire;
        issue(1, 28'h0000800, 7, 1, 32'h0);
        for (int c = 0; c < 500 && n_wfire < nw0 + 2; c++) @(negedge clk);
        chk("mid_burst_reached", 64'(n_wfire >= nw0 + 2), 64'd1);
        @(posedge clk); #2 rstn = 0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs("mid_rst");
        @(posedge clk); #1 rstn = 1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        rdy_pct = 100;
        issue(1, 28'h0000900, 0, 1, 32'h0);
        wait_done("post_rst_wr");
        issue(0, 28'h0000900, 0, 0, 32'h0);
        wait_done("post_rst_rd");

        for (int it = 0; it < 30; it++) begin
            rdy_pct  = int'($urandom_range(100, 30));
            host_pct = int'($urandom_range(100, 30));
            cfg_bresp = 2'($urandom);
            for (int i = 0; i < 256; i++) cfg_rresp[i] = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
            len = ($urandom_range(5, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(15, 0));
            cfg_rlast_beat = ($urandom_range(4, 0) == 0) ? int'($urandom_range(len + 1, 0)) : -1;
            a = 28'h0002000 + 28'($urandom_range(32'h1FFF, 0));
            issue(1'($urandom), a, len, 1, 32'h0);
            wait_done("random");
        end
        clear_cfg();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_axi_master.md
Name: ddr_axi_master

Overview:
AXI4 master that drives the board's ddr_* slave port (MIG) from a simple word-oriented request interface. It accepts one burst request at a time, runs the AW/W/B or AR/R sequence, and returns a single completion with the merged response code. It sits between the system bus/DMA logic and the board abstraction, in the sys_clk domain.

Parameters:
AXI_ID, 4'h0, constant value driven on ddr_awid/ddr_arid
MAX_LEN, 255, largest accepted req_len (beats-1); range 0..255

Ports:
clk  in  1  system clock (sys_clk)
rstn  in  1  reset; synchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  28  byte address; bits [1:0] ignored (forced 0)
req_len  in  8  beats-1
wr_valid  in  1  write-data beat valid
wr_ready  out  1  write-data beat taken
wr_data  in  32  write data
wr_strb  in  4  byte enables
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat taken
rd_data  out  32  read data
rd_last  out  1  last read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  merged response, valid with done
ddr_aw*/ddr_w*/ddr_b*/ddr_ar*/ddr_r*  AXI4 master, widths: id 4, addr 28, len 8, size 3, burst 2, cache 4, prot 3, qos 4, data 32, strb 4, resp 2

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE; req_ready=0 during reset, then 1 in IDLE; all *valid, ddr_bready, ddr_rready, wr_ready, done = 0; done_resp=0; counters 0.
- Constant fields: awsize/arsize=3'b010, awburst/arburst=2'b01 (INCR), cache=4'b0011, prot=0, qos=0, id=AXI_ID.
- req_ready=1 only in IDLE. On accept: latch addr (with [1:0]=0), len, we.
- Checks at accept: req_len>MAX_LEN, or addr[11:0]+4*(len+1)>4096 (4 KiB crossing) -> no AXI traffic, state DONE with done_resp=2'b10.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- WADDR: ddr_awvalid=1, awaddr/awlen held stable until awready; then WDATA.
- WDATA: ddr_wvalid=wr_valid, wr_ready=ddr_wready (combinational pass-through), wdata/wstrb passed through; beat counter increments per handshake; ddr_wlast=(cnt==len). After last handshake -> WRESP.
- WRESP: ddr_bready=1; on bvalid, latch bresp -> DONE. bid ignored.
- RADDR: ddr_arvalid=1 until arready -> RDATA.
- RDATA: rd_valid=ddr_rvalid, ddr_rready=rd_ready, rd_data=ddr_rdata, rd_last=(cnt==len). resp accumulates as max(rresp) over beats. Exit on handshake with cnt==len. If ddr_rlast disagrees with (cnt==len) on any beat, resp forced to 2'b10 (sticky) and exit still follows counter.
- DONE: done=1 for exactly one cycle, done_resp valid; next cycle IDLE (earliest new accept 2 cycles after last B/R handshake).
- Valid signals never deassert before their handshake (AXI stability rule); no W beats issued before AW handshake.
- Single outstanding transaction; no read/write overlap.
- Reset mid-burst: immediate return to IDLE, all outputs to reset values; no recovery of the interrupted AXI transaction (slave is reset together via sys_rst).
- Backpressure at any point (awready/wready/bvalid/rvalid/rd_ready low for N cycles) only stalls; no beat lost or duplicated.

Test Plan:
- Write len=0, addr 0x0000100, data 0xDEADBEEF, strb 0xF, slave ready always -> one AW (awlen=0, awaddr=0x100), one W with wlast=1, bresp=0 -> done pulse, done_resp=0.
- Write len=7 with random wready/awready stalls, then read len=7 same addr -> 8 rd beats match written data in order, rd_last only on beat 8, done_resp=0 for both.
- Read len=3 where slave returns rresp 0,1,2,0 -> done_resp=2'b10; data beats all delivered.
- Request addr 0x0000FF8, len=3 (crosses 4 KiB) -> no awvalid/arvalid ever, done after accept with done_resp=2'b10.
- Read len=3 where slave asserts rlast on beat 2 -> rd_last still on beat 4 only, done_resp=2'b10.
- rstn low during WDATA beat 3 of 8 -> next cycle all valids 0, state IDLE, req_ready=1 after rstn high; subsequent len=0 write completes normally.
